// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - funct3 size encodings and FSM states for the data memory unit
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte enables, store lane replication, load lane select/extension
// DMEM_MISALIGN_TRAP_EN: flag misaligned H/HU/W as errors instead of aligning the address down.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        err
);

    logic       illegal;
    logic [1:0] off;
    logic [7:0] rbyte;
    logic [15:0] rhalf;

    always_comb begin
        // unsigned sizes exist only for loads
        case (size)
            SZ_B, SZ_H, SZ_W: illegal = 1'b0;
            SZ_BU, SZ_HU:     illegal = we;
            default:          illegal = 1'b1;
        endcase

        off = addr_lo;
`ifdef DMEM_MISALIGN_TRAP_EN
        err = illegal
            | (((size == SZ_H) || (size == SZ_HU)) && addr_lo[0])
            | ((size == SZ_W) && (addr_lo != 2'b00));
`else
        err = illegal;
        if ((size == SZ_H) || (size == SZ_HU)) begin
            off[0] = 1'b0;
        end else if (size == SZ_W) begin
            off = 2'b00;
        end
`endif

        be    = 4'b0000;
        wword = wdata;
        case (size)
            SZ_B: begin
                be    = 4'b0001 << off;
                wword = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
            end
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        if (err || !we) begin
            be = 4'b0000;
        end

        rbyte = rword[{off, 3'b000} +: 8];
        rhalf = off[1] ? rword[31:16] : rword[15:0];
        rdata = 32'd0;
        if (!we && !err) begin
            case (size)
                SZ_B:    rdata = {{24{rbyte[7]}}, rbyte};
                SZ_H:    rdata = {{16{rhalf[15]}}, rhalf};
                SZ_W:    rdata = rword;
                SZ_BU:   rdata = {24'd0, rbyte};
                SZ_HU:   rdata = {16'd0, rhalf};
                default: rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_unit.sv
// rtl/data_mem_unit.sv - multi-cycle RISC-V load/store unit over an internal word array
// DMEM_MISALIGN_TRAP_EN (see dmem_lane_align) selects trapping on misaligned accesses.
module data_mem_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t state, next_state;
    logic [3:0]    count;
    logic          we_q;
    logic [2:0]    size_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rword_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept, enter_resp;
    logic          sel_we;
    logic [2:0]    sel_size;
    logic [AW+1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic [3:0]    be;
    logic [31:0]   wword, rdata_al;
    logic          err;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:AW+2];
    assign accept         = req_valid && (state == IDLE);
    assign enter_resp     = (next_state == RESP) && (state != RESP);

    // with LATENCY=1 the array is touched on the accept edge, before the latches hold the request
    assign sel_we    = (state == IDLE) ? req_we           : we_q;
    assign sel_size  = (state == IDLE) ? req_size         : size_q;
    assign sel_addr  = (state == IDLE) ? req_addr[AW+1:0] : addr_q;
    assign sel_wdata = (state == IDLE) ? req_wdata        : wdata_q;

    dmem_lane_align u_align (
        .we      (sel_we),
        .size    (sel_size),
        .addr_lo (sel_addr[1:0]),
        .wdata   (sel_wdata),
        .rword   (rword_q),
        .be      (be),
        .wword   (wword),
        .rdata   (rdata_al),
        .err     (err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= next_state;
            if (accept) begin
                count <= 4'(LATENCY - 1);
            end else if (state == WAIT) begin
                count <= count - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            addr_q  <= req_addr[AW+1:0];
            wdata_q <= req_wdata;
        end
    end

    // array and read word are intentionally not reset; rst gating drops an in-flight store
    always_ff @(posedge clk) begin
        if (enter_resp && !rst) begin
            rword_q <= mem[sel_addr[AW+1:2]];
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[sel_addr[AW+1:2]][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (LATENCY > 1) ? WAIT : RESP;
            WAIT:    if (count == 4'd1) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_rdata = resp_valid ? rdata_al : 32'd0;
        resp_err   = resp_valid && err;
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// tb/tb_data_mem_unit.sv - scoreboard bench for data_mem_unit
module tb_data_mem_unit;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    data_mem_unit #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        string       name;
    } resp_t;

    resp_t exp_q[$];
    resp_t obs_q[$];
    int    acc_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic expect_resp(input string name, input logic [31:0] rdata, input logic err);
        resp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.lat   = LAT;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    // drives one request from a negedge, returns at the negedge of its response
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit poke);
        resp_t o;
        int    n;
        int    acc;
        req_we = we; req_size = size; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        acc_q.push_back(acc);
        req_valid = 1'b0;
        if (poke) begin
            req_valid = 1'b1; req_we = 1'b1; req_size = 3'b010;
            req_addr = 32'h30; req_wdata = 32'hFFFF_FFFF;
        end
        o.rdata = 'x; o.err = 'x; o.lat = -1; o.name = "";
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 40);
        if (resp_valid) begin
            o.rdata = resp_rdata;
            o.err   = resp_err;
            o.lat   = cyc - acc + 1;
        end
        req_valid = 1'b0;
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", resp_valid); end
        total++; if (resp_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h want=0", resp_rdata); end
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", resp_err); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word();
        expect_resp("sw_10", 32'h0, 1'b0);         access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
        expect_resp("lw_10", 32'hDEADBEEF, 1'b0);  access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        while (exp_q.size() > 0) begin
            resp_t e = exp_q.pop_front();
            resp_t o = obs_q.pop_front();
            total++;
            if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat) begin
                bad++;
                $display("FAIL %s got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                         e.name, o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_byte();
        expect_resp("sb_13", 32'h0, 1'b0);          access(1'b1, 3'b000, 32'h13, 32'h80, 1'b0);
        expect_resp("lb_13", 32'hFFFFFF80, 1'b0);   access(1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
        expect_resp("lbu_13", 32'h00000080, 1'b0);  access(1'b0, 3'b100, 32'h13, 32'h0, 1'b0);
        expect_resp("lw_10b", 32'h80ADBEEF, 1'b0);  access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        while (exp_q.size() > 0) begin
            resp_t e = exp_q.pop_front();
            resp_t o = obs_q.pop_front();
            total++;
            if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat) begin
                bad++;
                $display("FAIL %s got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                         e.name, o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_half();
        expect_resp("sw_20", 32'h0, 1'b0);          access(1'b1, 3'b010, 32'h20, 32'h0, 1'b0);
        expect_resp("sh_22", 32'h0, 1'b0);          access(1'b1, 3'b001, 32'h22, 32'h1234F00D, 1'b0);
        expect_resp("lh_22", 32'hFFFFF00D, 1'b0);   access(1'b0, 3'b001, 32'h22, 32'h0, 1'b0);
        expect_resp("lhu_22", 32'h0000F00D, 1'b0);  access(1'b0, 3'b101, 32'h22, 32'h0, 1'b0);
        expect_resp("lw_20", 32'hF00D0000, 1'b0);   access(1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
        while (exp_q.size() > 0) begin
            resp_t e = exp_q.pop_front();
            resp_t o = obs_q.pop_front();
            total++;
            if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat) begin
                bad++;
                $display("FAIL %s got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                         e.name, o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_misalign();
`ifdef DMEM_MISALIGN_TRAP_EN
        expect_resp("lw_11", 32'h0, 1'b1);
        expect_resp("lh_13", 32'h0, 1'b1);
        expect_resp("lhu_11", 32'h0, 1'b1);
`else
        expect_resp("lw_11", 32'h80ADBEEF, 1'b0);
        expect_resp("lh_13", 32'hFFFF80AD, 1'b0);
        expect_resp("lhu_11", 32'h0000BEEF, 1'b0);
`endif
        access(1'b0, 3'b010, 32'h11, 32'h0, 1'b0);
        access(1'b0, 3'b001, 32'h13, 32'h0, 1'b0);
        access(1'b0, 3'b101, 32'h11, 32'h0, 1'b0);
        while (exp_q.size() > 0) begin
            resp_t e = exp_q.pop_front();
            resp_t o = obs_q.pop_front();
            total++;
            if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat) begin
                bad++;
                $display("FAIL %s got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                         e.name, o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_illegal();
        expect_resp("ld_011", 32'h0, 1'b1);   access(1'b0, 3'b011, 32'h10, 32'h0, 1'b0);
        expect_resp("ld_110", 32'h0, 1'b1);   access(1'b0, 3'b110, 32'h10, 32'h0, 1'b0);
        expect_resp("ld_111", 32'h0, 1'b1);   access(1'b0, 3'b111, 32'h10, 32'h0, 1'b0);
        expect_resp("st_100", 32'h0, 1'b1);   access(1'b1, 3'b100, 32'h10, 32'h0, 1'b0);
        expect_resp("st_101", 32'h0, 1'b1);   access(1'b1, 3'b101, 32'h10, 32'h0, 1'b0);
        expect_resp("lw_10c", 32'h80ADBEEF, 1'b0); access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        while (exp_q.size() > 0) begin
            resp_t e = exp_q.pop_front();
            resp_t o = obs_q.pop_front();
            total++;
            if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat) begin
                bad++;
                $display("FAIL %s got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                         e.name, o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_alias();
        expect_resp("sw_1010", 32'h0, 1'b0);           access(1'b1, 3'b010, 32'h1010, 32'hCAFEF00D, 1'b0);
        expect_resp("lw_10_alias", 32'hCAFEF00D, 1'b0); access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        expect_resp("lw_hi_alias", 32'hCAFEF00D, 1'b0); access(1'b0, 3'b010, 32'hFFFFF010, 32'h0, 1'b0);
        while (exp_q.size() > 0) begin
            resp_t e = exp_q.pop_front();
            resp_t o = obs_q.pop_front();
            total++;
            if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat) begin
                bad++;
                $display("FAIL %s got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                         e.name, o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        acc_q.delete();
        expect_resp("b2b_sw", 32'h0, 1'b0);          access(1'b1, 3'b010, 32'h50, 32'hA5A5A5A5, 1'b0);
        expect_resp("b2b_lw", 32'hA5A5A5A5, 1'b0);   access(1'b0, 3'b010, 32'h50, 32'h0, 1'b0);
        expect_resp("b2b_sb", 32'h0, 1'b0);          access(1'b1, 3'b000, 32'h51, 32'h3C, 1'b0);
        expect_resp("b2b_lw2", 32'hA5A53CA5, 1'b0);  access(1'b0, 3'b010, 32'h50, 32'h0, 1'b0);
        for (int i = 1; i < acc_q.size(); i++) begin
            total++;
            if (acc_q[i] - acc_q[i-1] != LAT + 1) begin
                bad++;
                $display("FAIL b2b_gap%0d got=%0d want=%0d", i, acc_q[i] - acc_q[i-1], LAT + 1);
            end
        end
        while (exp_q.size() > 0) begin
            resp_t e = exp_q.pop_front();
            resp_t o = obs_q.pop_front();
            total++;
            if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat) begin
                bad++;
                $display("FAIL %s got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                         e.name, o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_busy_ignore();
        expect_resp("sw_30", 32'h0, 1'b0);             access(1'b1, 3'b010, 32'h30, 32'h0BADC0DE, 1'b0);
        expect_resp("lw_30_poke", 32'h0BADC0DE, 1'b0); access(1'b0, 3'b010, 32'h30, 32'h0, 1'b1);
        expect_resp("lw_30_after", 32'h0BADC0DE, 1'b0); access(1'b0, 3'b010, 32'h30, 32'h0, 1'b0);
        while (exp_q.size() > 0) begin
            resp_t e = exp_q.pop_front();
            resp_t o = obs_q.pop_front();
            total++;
            if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat) begin
                bad++;
                $display("FAIL %s got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                         e.name, o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_mid_reset();
        int n;
        bit seen;
        expect_resp("sw_40_prior", 32'h0, 1'b0); access(1'b1, 3'b010, 32'h40, 32'h11111111, 1'b0);
        req_we = 1'b1; req_size = 3'b010; req_addr = 32'h40; req_wdata = 32'h55AA55AA; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", seen); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", req_ready); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL midrst_post got=%b want=0", resp_valid); end
        expect_resp("lw_40_after_rst", 32'h11111111, 1'b0); access(1'b0, 3'b010, 32'h40, 32'h0, 1'b0);
        while (exp_q.size() > 0) begin
            resp_t e = exp_q.pop_front();
            resp_t o = obs_q.pop_front();
            total++;
            if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat) begin
                bad++;
                $display("FAIL %s got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                         e.name, o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_illegal();
        test_alias();
        test_back_to_back();
        test_busy_ignore();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
